// File: rtl/bank_seq_if.sv
//==============================================================================
// Module   : bank_seq_if
// Brief    : Handshake/RAM-port bundle between bank_seq_ctrl and its surroundings.
// Revision : 1.0
//==============================================================================
`default_nettype none

interface bank_seq_if #(
  parameter int AW = 11
);
  logic          start;
  logic          lock;
  logic          wrvalid;
  logic          wrready;
  logic          ena;
  logic          wea;
  logic [AW-1:0] addra;
  logic          enb;
  logic [AW-1:0] addrb;
  logic          rdvalid;
  logic          rdready;
  logic [2:0]    selectline;
  logic          busy;
  logic          complete;
  logic          abort;

  modport slave (
    input  start, lock, wrvalid, rdready,
    output wrready, ena, wea, addra, enb, addrb, rdvalid, selectline,
           busy, complete, abort
  );

  modport master (
    output start, lock, wrvalid, rdready,
    input  wrready, ena, wea, addra, enb, addrb, rdvalid, selectline,
           busy, complete, abort
  );
endinterface

`default_nettype wire

// File: rtl/bank_seq_ctrl.sv
//==============================================================================
// Module   : bank_seq_ctrl
// Brief    : Fill/turnaround/drain sequencer for a dual-port buffer RAM with
//            optional 8-way output steering (enabled by BANK_SEQ_STEER_EN).
// Revision : 1.0
//==============================================================================
`default_nettype none

module bank_seq_ctrl #(
  parameter int DEPTH = 2048,
  parameter int AW    = 11
) (
  input  logic     clk,
  input  logic     resetn,
  bank_seq_if.slave bus
);

  localparam logic [AW:0] LAST_IDX  = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_TURN  = 2'd2,
    S_READ  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [AW:0] wr_cnt_q;
  logic [AW:0] iss_cnt_q;
  logic [AW:0] beat_cnt_q;
  logic        rdvalid_q;
  logic        complete_q, complete_d;
  logic        abort_q, abort_d;

  logic        w_wrready;
  logic        w_wr_acc;
  logic        w_enb;
  logic        w_rd_acc;

  always_comb begin
    state_d    = state_q;
    complete_d = 1'b0;
    abort_d    = 1'b0;
    // Every enable is qualified by lock so a lost lock gates the RAM the same cycle.
    w_wrready  = (state_q == S_WRITE) && bus.lock;
    w_wr_acc   = w_wrready && bus.wrvalid;
    w_enb      = (state_q == S_READ) && bus.lock && (iss_cnt_q < DEPTH_CNT) &&
                 (!rdvalid_q || bus.rdready);
    w_rd_acc   = rdvalid_q && bus.rdready;

    case (state_q)
      S_IDLE: begin
        if (bus.start && bus.lock) state_d = S_WRITE;
      end
      S_WRITE: begin
        if (!bus.lock) begin
          state_d = S_IDLE;
          abort_d = 1'b1;
        end else if (w_wr_acc && (wr_cnt_q == LAST_IDX)) begin
          state_d = S_TURN;
        end
      end
      S_TURN: begin
        if (!bus.lock) begin
          state_d = S_IDLE;
          abort_d = 1'b1;
        end else begin
          state_d = S_READ;
        end
      end
      S_READ: begin
        if (!bus.lock) begin
          state_d = S_IDLE;
          abort_d = 1'b1;
        end else if (w_rd_acc && (beat_cnt_q == LAST_IDX)) begin
          state_d    = S_IDLE;
          complete_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      wr_cnt_q   <= '0;
      iss_cnt_q  <= '0;
      beat_cnt_q <= '0;
      rdvalid_q  <= 1'b0;
      complete_q <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      complete_q <= complete_d;
      abort_q    <= abort_d;
      // Returning to IDLE (done or aborted) leaves every run starting from zero.
      if (state_d == S_IDLE) begin
        wr_cnt_q   <= '0;
        iss_cnt_q  <= '0;
        beat_cnt_q <= '0;
        rdvalid_q  <= 1'b0;
      end else begin
        if (w_wr_acc) wr_cnt_q   <= wr_cnt_q + 1'b1;
        if (w_enb)    iss_cnt_q  <= iss_cnt_q + 1'b1;
        if (w_rd_acc) beat_cnt_q <= beat_cnt_q + 1'b1;
        if (w_enb)         rdvalid_q <= 1'b1;
        else if (w_rd_acc) rdvalid_q <= 1'b0;
      end
    end
  end

`ifdef BANK_SEQ_STEER_EN
  logic [2:0] sel_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sel_q <= 3'd0;
    end else if (state_d == S_IDLE) begin
      sel_q <= 3'd0;
    end else if (w_rd_acc) begin
      sel_q <= sel_q + 3'd1;
    end
  end

  assign bus.selectline = sel_q;
`else
  assign bus.selectline = 3'd0;
`endif

  assign bus.wrready  = w_wrready;
  assign bus.ena      = w_wr_acc;
  assign bus.wea      = w_wr_acc;
  assign bus.addra    = wr_cnt_q[AW-1:0];
  assign bus.enb      = w_enb;
  assign bus.addrb    = iss_cnt_q[AW-1:0];
  assign bus.rdvalid  = rdvalid_q;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.complete = complete_q;
  assign bus.abort    = abort_q;

endmodule

`default_nettype wire

// File: tb/tb_bank_seq_ctrl.sv
//==============================================================================
// Module   : tb_bank_seq_ctrl
// Brief    : Scoreboard bench for bank_seq_ctrl (DEPTH=16, AW=4) with RAM model.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_bank_seq_ctrl;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  bank_seq_if #(.AW(AW)) bus ();

  bank_seq_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Buffer RAM model, read latency 1.
  logic [7:0] mem [0:DEPTH-1];
  logic [7:0] ram_wdata = 8'h00;
  logic [7:0] ram_rdata = 8'h00;
  always @(posedge clk) begin
    if (bus.ena && bus.wea) mem[bus.addra] <= ram_wdata;
    if (bus.enb) ram_rdata <= mem[bus.addrb];
  end

  // Source/sink handshake driver.
  logic rand_mode = 1'b0;
  logic wr_alt = 1'b0;
  logic rd_alt = 1'b0;
  initial begin
    bus.wrvalid = 1'b0;
    bus.rdready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rand_mode) begin
        bus.wrvalid = 1'($urandom);
        bus.rdready = 1'($urandom);
      end else begin
        bus.wrvalid = wr_alt ? ~bus.wrvalid : 1'b1;
        bus.rdready = rd_alt ? ~bus.rdready : 1'b1;
      end
    end
  end

  // Monitor / scoreboard state.
  logic [7:0] sb[$];
  int clr_gen = 0;
  int seen_gen = 0;
  int wr_beats, rd_beats, n_complete, n_abort, complete_cyc, abort_cyc;
  int first_wea, last_wea, first_enb, last_enb, first_rdv, last_rdv, wrready_cycles;
  int exp_waddr = 0, exp_raddr = 0, run_rd = 0, src_idx = 0;
  logic stalled_prev = 1'b0;
  logic [7:0] held_data = 8'h00;
  logic [7:0] exp_d;
  logic [2:0] exp_sel;

  initial begin
    forever begin
      @(negedge clk);
      if (seen_gen != clr_gen) begin
        seen_gen = clr_gen;
        wr_beats = 0; rd_beats = 0; n_complete = 0; n_abort = 0;
        complete_cyc = -1; abort_cyc = -1; wrready_cycles = 0;
        first_wea = -1; last_wea = -1; first_enb = -1; last_enb = -1;
        first_rdv = -1; last_rdv = -1;
      end
      if (resetn) begin
        if (!bus.lock)
          chk("gated_on_lock_low", {28'd0, bus.wrready, bus.ena, bus.wea, bus.enb}, 32'd0);
        if (bus.wrready) wrready_cycles++;
        if (bus.ena && bus.wea) begin
          chk("addra", 32'(bus.addra), 32'(exp_waddr));
          ram_wdata = 8'h5A + 8'(src_idx * 13);
          sb.push_back(ram_wdata);
          src_idx++; exp_waddr++; wr_beats++;
          if (first_wea < 0) first_wea = cyc;
          last_wea = cyc;
        end
        if (bus.enb) begin
          chk("addrb", 32'(bus.addrb), 32'(exp_raddr));
          exp_raddr++;
          if (first_enb < 0) first_enb = cyc;
          last_enb = cyc;
        end
        if (stalled_prev)
          chk("rdvalid_hold", {23'd0, bus.rdvalid, ram_rdata}, {23'd0, 1'b1, held_data});
        stalled_prev = bus.rdvalid && !bus.rdready;
        held_data    = ram_rdata;
        if (bus.rdvalid) begin
          if (first_rdv < 0) first_rdv = cyc;
          last_rdv = cyc;
        end
        if (bus.rdvalid && bus.rdready) begin
          if (sb.size() == 0) begin
            chk("rd_unexpected", 32'd1, 32'd0);
          end else begin
            exp_d = sb.pop_front();
            chk("rd_data", 32'(ram_rdata), 32'(exp_d));
          end
`ifdef BANK_SEQ_STEER_EN
          exp_sel = 3'(run_rd);
`else
          exp_sel = 3'd0;
`endif
          chk("selectline", 32'(bus.selectline), 32'(exp_sel));
          run_rd++; rd_beats++;
        end
        if (bus.complete || bus.abort) begin
          if (bus.complete) begin n_complete++; complete_cyc = cyc; end
          if (bus.abort) begin n_abort++; abort_cyc = cyc; sb.delete(); end
          exp_waddr = 0; exp_raddr = 0; run_rd = 0; stalled_prev = 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    clr_gen++;
    @(negedge clk);
    step();
  endtask

  task automatic wait_end(input int maxc);
    int k = 0;
    while (n_complete == 0 && n_abort == 0 && k < maxc) begin
      step();
      k++;
    end
    if (k >= maxc) chk("run_timeout", 32'd1, 32'd0);
    step();
  endtask

  task automatic wait_cond_wr(input int n, input int maxc);
    int k = 0;
    while (wr_beats < n && k < maxc) begin
      step();
      k++;
    end
    if (k >= maxc) chk("wr_wait_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_cond_rd(input int n, input int maxc);
    int k = 0;
    while (rd_beats < n && k < maxc) begin
      step();
      k++;
    end
    if (k >= maxc) chk("rd_wait_timeout", 32'd1, 32'd0);
  endtask

  function automatic logic [31:0] all_outputs();
    return {13'd0, bus.wrready, bus.ena, bus.wea, bus.addra, bus.enb, bus.addrb,
            bus.rdvalid, bus.selectline, bus.busy, bus.complete, bus.abort};
  endfunction

  int t0, tl;

  initial begin
    bus.start = 1'b0;
    bus.lock  = 1'b0;
    rand_mode = 1'b1;

    // Reset held with random inputs, then idle after release.
    for (int i = 0; i < 5; i++) begin
      step();
      bus.start = 1'($urandom);
      bus.lock  = 1'($urandom);
      @(negedge clk);
      chk("reset_outputs", all_outputs(), 32'd0);
    end
    step();
    rand_mode = 1'b0;
    bus.start = 1'b0;
    bus.lock  = 1'b1;
    resetn    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_outputs", all_outputs(), 32'd0);
      step();
    end

    // Full run, continuous handshakes.
    wr_alt = 1'b0; rd_alt = 1'b0;
    clear_stats();
    bus.start = 1'b1; t0 = cyc;
    step();
    bus.start = 1'b0;
    wait_end(100);
    chk("full_first_wea", 32'(first_wea), 32'(t0 + 1));
    chk("full_last_wea", 32'(last_wea), 32'(t0 + 16));
    chk("full_first_enb", 32'(first_enb), 32'(t0 + 18));
    chk("full_last_enb", 32'(last_enb), 32'(t0 + 33));
    chk("full_first_rdvalid", 32'(first_rdv), 32'(t0 + 19));
    chk("full_last_rdvalid", 32'(last_rdv), 32'(t0 + 34));
    chk("full_complete_cycle", 32'(complete_cyc), 32'(t0 + 35));
    chk("full_beats", 32'(rd_beats), 32'd16);
    chk("full_counts", {16'(n_complete), 16'(n_abort)}, {16'd1, 16'd0});
    chk("full_busy_after", 32'(bus.busy), 32'd0);

    // Read backpressure.
    rd_alt = 1'b1;
    clear_stats();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_end(200);
    step(); step();
    chk("bp_beats", 32'(rd_beats), 32'd16);
    chk("bp_counts", {16'(n_complete), 16'(n_abort)}, {16'd1, 16'd0});
    chk("bp_sb_empty", 32'(sb.size()), 32'd0);

    // Write bubbles.
    rd_alt = 1'b0; wr_alt = 1'b1;
    clear_stats();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_end(200);
    chk("bubble_write_len", 32'((wrready_cycles >= 31) && (wrready_cycles <= 32)), 32'd1);
    chk("bubble_beats", {16'(wr_beats), 16'(rd_beats)}, {16'd16, 16'd16});
    chk("bubble_complete", 32'(n_complete), 32'd1);

    // Lock loss at write beat 5.
    wr_alt = 1'b0;
    clear_stats();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_cond_wr(5, 50);
    bus.lock = 1'b0; tl = cyc;
    #1;
    chk("lockloss_wea", {30'd0, bus.ena, bus.wea}, 32'd0);
    wait_end(20);
    chk("lockloss_abort_cycle", 32'(abort_cyc), 32'(tl + 1));
    chk("lockloss_counts", {16'(n_complete), 16'(n_abort)}, {16'd0, 16'd1});
    chk("lockloss_wr_beats", 32'(wr_beats), 32'd5);
    chk("lockloss_busy", 32'(bus.busy), 32'd0);
    bus.lock = 1'b1;
    step();
    clear_stats();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_end(100);
    chk("restart_counts", {16'(n_complete), 16'(rd_beats)}, {16'd1, 16'd16});

    // start pulsed during READ is ignored.
    clear_stats();
    bus.start = 1'b1; t0 = cyc;
    step();
    bus.start = 1'b0;
    wait_cond_rd(3, 60);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_end(100);
    chk("ignstart_complete_cycle", 32'(complete_cyc), 32'(t0 + 35));
    step(); step(); step();
    chk("ignstart_idle", {31'd0, bus.busy}, 32'd0);
    chk("ignstart_counts", {16'(n_complete), 16'(n_abort)}, {16'd1, 16'd0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/bank_seq_ctrl.md
# bank_seq_ctrl

Single-clock sequencer for one dual-port buffer RAM and its 8-way output steering. On `start` with `lock` high it fills the RAM through port A from a valid/ready source, takes a one-cycle turnaround, then drains port B to a valid/ready sink while rotating `selectline` per accepted word. It pulses `complete` when done. Losing `lock` mid-run aborts the sequence cleanly.

## Interface
- `DEPTH`, 2048: words per fill/drain pass; 2 ≤ DEPTH ≤ 2^AW
- `AW`, 11: RAM address width
- `clk` in 1: sole clock, rising edge
- `resetn` in 1: asynchronous, active-low reset
- `start` in 1: run request; sampled only in IDLE
- `lock` in 1: clock-lock qualifier; must be high to start; low mid-run aborts
- `wrvalid` in 1: source word available
- `wrready` out 1: controller accepts source word
- `ena` out 1: RAM port A enable
- `wea` out 1: RAM port A write enable
- `addra` out AW: port A address
- `enb` out 1: RAM port B read enable (RAM read latency fixed at 1)
- `addrb` out AW: port B address
- `rdvalid` out 1: RAM output word valid to sink
- `rdready` in 1: sink accepts word
- `selectline` out 3: steering lane for the word currently on `rdvalid`
- `busy` out 1: state ≠ IDLE
- `complete` out 1: one-cycle pulse after the last read beat is accepted
- `abort` out 1: one-cycle pulse after a lock-loss abort

## Operation
- States:
  - IDLE → WRITE when `start && lock`.
  - WRITE → TURN on accepted write beat DEPTH-1.
  - TURN → READ unconditionally; TURN lasts one cycle with all enables low.
  - READ → IDLE when the last beat is accepted; `complete` is registered that cycle.
- WRITE:
  - `wrready=1`.
  - Accept = `wrvalid && wrready`.
  - `ena=wea=accept` (combinational); `addra` = write counter, incremented on accept.
- READ issue:
  - `enb = (issued < DEPTH) && (!rdvalid || rdready)` (combinational); `addrb` = issue counter, incremented when `enb`.
  - `rdvalid` is registered from `enb`.
  - A stalled `rdvalid` holds, and no new issue occurs.
- Beat counter increments on `rdvalid && rdready`. `selectline` advances (selectline+1) mod 8 on the same event; it wraps 7→0.
- Counters are AW+1 bits wide. Terminal compares are against DEPTH-1, so DEPTH = 2^AW is legal.
- Abort:
  - If `lock=0` in WRITE, TURN or READ, the next state is IDLE.
  - `abort` pulses on the next cycle; `complete` does not pulse.
  - Counters, `rdvalid` and `selectline` are cleared.
  - Enables are gated off the same cycle `lock` is low.
- `start` outside IDLE is ignored.
- `start` high with `lock` low in IDLE is ignored; no latch.
- Every run begins at address 0 and `selectline` 0.

## Timing
- Reset (async assert, sync release): state IDLE, all counters 0. All outputs are 0, including `selectline`.
- Cycle 0 `start&&lock` in IDLE → cycle 1 WRITE, `wrready=1`.
- With continuous `wrvalid`/`rdready`:
  - Writes on cycles 1..DEPTH.
  - TURN on DEPTH+1.
  - `enb` on DEPTH+2..2·DEPTH+1.
  - `rdvalid` on DEPTH+3..2·DEPTH+2.
  - `complete` and IDLE on 2·DEPTH+3.
- Read latency: `enb` → `rdvalid` is 1 cycle.
- Back-to-back runs: `start` is accepted in the cycle `complete` is high, because the state is already IDLE.
- `resetn` asserted mid-run returns to IDLE immediately, with no `abort`/`complete` pulse.

## Configuration
- `BANK_SEQ_STEER_EN` defined: `selectline` rotates as described.
- Undefined: `selectline` is tied to 0 and the rotation logic is absent. All other behaviour is identical.

## Test plan
- Reset: hold `resetn=0` with random inputs → every output 0, `busy=0`. Release, idle 5 cycles → outputs remain 0.
- Full run, DEPTH=16 AW=4, `wrvalid=rdready=1`, `start` at cycle 0:
  - `wea` on cycles 1–16 with `addra` 0..15.
  - TURN at 17.
  - `enb` 18–33 with `addrb` 0..15.
  - `rdvalid` 19–34 with `selectline` 0..7,0..7.
  - `complete` at 35.
- Read backpressure: `rdready` alternating 1/0 → `rdvalid` holds while stalled. `addrb` and `selectline` advance only on accept. Exactly 16 beats, then one `complete`.
- Write bubbles: `wrvalid` every other cycle → `addra` advances only on accept, WRITE lasts 31–32 cycles, and read results match the written data order.
- Lock loss: drop `lock` at write beat 5 → `wea` low that cycle, `abort` pulse next cycle, IDLE, no `complete`. Re-`start` → `addra` restarts at 0.
- `start` pulsed during READ → ignored. With `BANK_SEQ_STEER_EN` undefined, the full run shows `selectline`=0 throughout.
